knn_bram_scan_ctrl: RTL and testbench
=====================================

Name: knn_bram_scan_ctrl

Overview:
- Sequencer and access arbiter for the single-port training-vector block RAM of the KNN classifier (256-bit words, 512-deep, read-first, 1-cycle registered read, data output updates only when the read enable is high).
- On `start`, streams every stored training vector from SCAN_START to SCAN_END to the distance-compute stage over a valid/ready handshake.
- Outside a scan, grants single-word host writes for loading the RAM.

Parameters:
- RAM_WIDTH, 256, width of one training vector word.
- RAM_ADDR_BITS, 9, RAM address width.
- SCAN_START, 0, first address scanned.
- SCAN_END, 299, last address scanned (inclusive); must satisfy SCAN_END >= SCAN_START.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- busy  out  1  high in SCAN or DRAIN.
- done  out  1  one-cycle pulse after the last vector is accepted.
- host_wr_req  in  1  host write request; level, held until acked.
- host_wr_addr  in  RAM_ADDR_BITS  host write address.
- host_wr_data  in  RAM_WIDTH  host write data.
- host_wr_ack  out  1  one-cycle pulse in the cycle the write is issued to the RAM.
- ram_r  out  1  RAM enable; a write requires ram_r=1 and ram_w=1.
- ram_w  out  1  RAM write enable.
- ram_addr  out  RAM_ADDR_BITS  RAM address.
- ram_din  out  RAM_WIDTH  RAM write data; equals host_wr_data.
- ram_dout  in  RAM_WIDTH  RAM registered read data.
- vec_valid  out  1  stream valid (registered).
- vec_ready  in  1  downstream ready.
- vec_data  out  RAM_WIDTH  combinational pass-through of ram_dout.
- vec_idx  out  RAM_ADDR_BITS  address of the presented vector (registered).
- vec_last  out  1  high while the presented vector is SCAN_END (registered).

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, addr_cnt=SCAN_START.
  - vec_valid, vec_idx, vec_last, done, host_wr_ack = 0.
  - ram_r, ram_w = 0.
  - Reset mid-scan abandons the scan; no done pulse.
- ram_r/ram_w/ram_addr/host_wr_ack are combinational from state, addr_cnt and inputs.
- issue = state==SCAN && (!vec_valid || vec_ready).
- States:
  - IDLE:
    - If start: go to SCAN, addr_cnt=SCAN_START.
    - Else if host_wr_req: ram_r=1, ram_w=1, ram_addr=host_wr_addr, host_wr_ack=1 in the same cycle; stay IDLE.
    - If start and host_wr_req are high together, start wins; the write waits until the scan completes.
  - SCAN:
    - On issue: ram_r=1, ram_w=0, ram_addr=addr_cnt.
    - At the following edge: vec_valid<=1, vec_idx<=addr_cnt, vec_last<=(addr_cnt==SCAN_END), addr_cnt increments.
    - Issuing SCAN_END moves the state to DRAIN.
    - When not issuing: ram_r=0, so the RAM output (vec_data) holds stable under backpressure.
    - vec_valid falls only on accept with no new issue.
  - DRAIN:
    - ram_r=0.
    - On vec_valid && vec_ready && vec_last: vec_valid<=0, done<=1 for one cycle, go to IDLE.
- Host writes are never granted in SCAN or DRAIN; host_wr_req is held off and host_wr_ack stays 0.
- Latency:
  - start sampled at edge E0 -> first vec_valid after E1.
  - With vec_ready held high: one vector per cycle, (SCAN_END-SCAN_START+1) consecutive cycles, no bubbles.
  - done asserts the cycle after the last accept.
- Ordering: vec_idx strictly increments by 1 from SCAN_START to SCAN_END; addr_cnt never wraps.
- start in SCAN or DRAIN is ignored.
- Case SCAN_END == SCAN_START: a single vector with vec_last=1.

Optional Feature:
- Macro: KNN_SCAN_ABORT_EN.
- Defined: adds input `abort` (1) and output `aborted` (1, one-cycle pulse).
  - abort high in SCAN or DRAIN: at the next edge, vec_valid<=0, vec_last<=0, state<=IDLE, addr_cnt<=SCAN_START, aborted<=1.
  - ram_r=0 in the cycle abort is high; done is not pulsed.
  - abort takes priority over accept or issue in the same cycle.
  - abort in IDLE is ignored.
- Undefined: neither port exists; scans always run to completion.

Test Plan:
- Load then scan: host writes word k = k for k=0..299 (300 acks, ram_w=1 each); pulse start with vec_ready=1 -> vec_idx 0..299 on 300 consecutive cycles, vec_data==vec_idx, vec_last only at 299, done pulse 1 cycle later.
- Backpressure: vec_ready=0 for 5 cycles while vec_idx=10 -> vec_data and vec_idx hold, ram_r=0 during the stall; next accept shows idx 11 with no skip or duplicate.
- Arbitration: start and host_wr_req in the same IDLE cycle -> scan starts with no ack; ack occurs the first IDLE cycle after done, with addr/data as presented.
- Reset mid-scan: assert rst at vec_idx=150 -> outputs 0 immediately, no done; a new start rescans from 0.
- Parameter SCAN_START=5, SCAN_END=5: start -> single vector, idx 5, vec_last=1, done after accept.
- KNN_SCAN_ABORT_EN: abort at idx=40 with vec_ready=1 -> aborted pulse, vec_valid=0 next cycle, no done; a following start streams from idx 0.

Source files
------------

// File: rtl/knn_bram_scan_ctrl.sv
// knn_bram_scan_ctrl
// Scan sequencer and access arbiter for the KNN training-vector block RAM.
// The RAM is single-port and read-first, with a 1-cycle registered read.
// Its output register updates only while ram_r is high.
// A start request streams words SCAN_START..SCAN_END to the distance stage
// over a valid/ready handshake. Outside a scan, host writes are granted
// one word per cycle.
// Optional build macro: KNN_SCAN_ABORT_EN. It adds the abort input and the
// aborted pulse output, which cut a running scan short.
//
// state | meaning
// IDLE  | no scan; host writes granted, start sampled
// SCAN  | issuing reads SCAN_START..SCAN_END, streaming results
// DRAIN | last address issued, waiting for the last vector to be accepted
module knn_bram_scan_ctrl #(
   parameter int RAM_WIDTH     = 256,
   parameter int RAM_ADDR_BITS = 9,
   parameter int SCAN_START    = 0,
   parameter int SCAN_END      = 299
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic                     host_wr_req,
   input  logic [RAM_ADDR_BITS-1:0] host_wr_addr,
   input  logic [RAM_WIDTH-1:0]     host_wr_data,
   output logic                     host_wr_ack,
   output logic                     ram_r,
   output logic                     ram_w,
   output logic [RAM_ADDR_BITS-1:0] ram_addr,
   output logic [RAM_WIDTH-1:0]     ram_din,
   input  logic [RAM_WIDTH-1:0]     ram_dout,
   output logic                     vec_valid,
   input  logic                     vec_ready,
   output logic [RAM_WIDTH-1:0]     vec_data,
   output logic [RAM_ADDR_BITS-1:0] vec_idx,
   output logic                     vec_last
`ifdef KNN_SCAN_ABORT_EN
   ,
   input  logic                     abort,
   output logic                     aborted
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [RAM_ADDR_BITS-1:0] START_A = RAM_ADDR_BITS'(SCAN_START);
   localparam logic [RAM_ADDR_BITS-1:0] END_A   = RAM_ADDR_BITS'(SCAN_END);

   logic [1:0]               state;
   logic [RAM_ADDR_BITS-1:0] addr_cnt;
   logic                     issue;
   logic                     wr_grant;
   logic                     abort_hit;

`ifdef KNN_SCAN_ABORT_EN
   assign abort_hit = abort && (state != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // An abort suppresses the issue in its own cycle, so no RAM read is started.
   // The write grant is held low during reset so the RAM sees no enable.
   assign issue    = (state == SCAN) && (!vec_valid || vec_ready) && !abort_hit;
   assign wr_grant = !rst && (state == IDLE) && !start && host_wr_req;

   assign busy        = (state == SCAN) || (state == DRAIN);
   assign host_wr_ack = wr_grant;
   assign ram_r       = wr_grant || issue;
   assign ram_w       = wr_grant;
   assign ram_addr    = (state == IDLE) ? host_wr_addr : addr_cnt;
   assign ram_din     = host_wr_data;
   assign vec_data    = ram_dout;

   // Sequencer state, address counter and the registered stream sideband.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_cnt  <= START_A;
         vec_valid <= 1'b0;
         vec_idx   <= '0;
         vec_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort_hit) begin
            state     <= IDLE;
            addr_cnt  <= START_A;
            vec_valid <= 1'b0;
            vec_last  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state    <= SCAN;
                     addr_cnt <= START_A;
                  end
               end
               SCAN: begin
                  if (issue) begin
                     vec_valid <= 1'b1;
                     vec_idx   <= addr_cnt;
                     vec_last  <= (addr_cnt == END_A);
                     // Hold at the end address rather than wrap past it.
                     if (addr_cnt == END_A) state <= DRAIN;
                     else addr_cnt <= addr_cnt + 1'b1;
                  end else if (vec_valid && vec_ready) begin
                     vec_valid <= 1'b0;
                  end
               end
               DRAIN: begin
                  if (vec_valid && vec_ready && vec_last) begin
                     vec_valid <= 1'b0;
                     vec_last  <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef KNN_SCAN_ABORT_EN
   // One-cycle pulse marking a scan that was cut short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) aborted <= 1'b0;
      else aborted <= abort_hit;
   end
`endif

endmodule

// File: tb/tb_knn_bram_scan_ctrl.sv
// Directed bench for knn_bram_scan_ctrl: load, stream, backpressure,
// arbitration, reset mid-scan, single-vector scan and optional abort.
module tb_knn_bram_scan_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   int           total = 0;
   int           passed = 0;
   int           fails = 0;

   // main instance, default scan range 0..299
   logic         start, busy, done, host_wr_req, host_wr_ack;
   logic         ram_r, ram_w, vec_valid, vec_ready, vec_last;
   logic [8:0]   host_wr_addr, ram_addr, vec_idx;
   logic [255:0] host_wr_data, ram_din, ram_dout, vec_data;
   logic [255:0] mem_a [512];

   // single-vector instance, scan range 5..5
   logic         start5, busy5, done5, req5, ack5;
   logic         ram_r5, ram_w5, valid5, ready5, last5;
   logic [8:0]   addr5, ram_addr5, idx5;
   logic [255:0] wdata5, ram_din5, ram_dout5, data5;
   logic [255:0] mem_b [512];

`ifdef KNN_SCAN_ABORT_EN
   logic abort, aborted, abort5, aborted5;
`endif

   always #5 clk = ~clk;

   knn_bram_scan_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr),
      .host_wr_data(host_wr_data), .host_wr_ack(host_wr_ack),
      .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .vec_data(vec_data), .vec_idx(vec_idx), .vec_last(vec_last)
`ifdef KNN_SCAN_ABORT_EN
      , .abort(abort), .aborted(aborted)
`endif
   );

   knn_bram_scan_ctrl #(.SCAN_START(5), .SCAN_END(5)) u_dut5 (
      .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5),
      .host_wr_req(req5), .host_wr_addr(addr5),
      .host_wr_data(wdata5), .host_wr_ack(ack5),
      .ram_r(ram_r5), .ram_w(ram_w5), .ram_addr(ram_addr5), .ram_din(ram_din5),
      .ram_dout(ram_dout5), .vec_valid(valid5), .vec_ready(ready5),
      .vec_data(data5), .vec_idx(idx5), .vec_last(last5)
`ifdef KNN_SCAN_ABORT_EN
      , .abort(abort5), .aborted(aborted5)
`endif
   );

   // read-first RAM models with registered output gated by enable
   always @(posedge clk) begin
      if (ram_r) begin
         if (ram_w) mem_a[ram_addr] <= ram_din;
         ram_dout <= mem_a[ram_addr];
      end
      if (ram_r5) begin
         if (ram_w5) mem_b[ram_addr5] <= ram_din5;
         ram_dout5 <= mem_b[ram_addr5];
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic early_ack;
      rst = 1'b1; start = 1'b0; host_wr_req = 1'b0; host_wr_addr = '0;
      host_wr_data = '0; vec_ready = 1'b0;
      start5 = 1'b0; req5 = 1'b0; addr5 = '0; wdata5 = '0; ready5 = 1'b0;
`ifdef KNN_SCAN_ABORT_EN
      abort = 1'b0; abort5 = 1'b0;
`endif

      // reset state
      @(negedge clk); #1;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_valid", vec_valid, 1'b0);
      chk1("rst_last", vec_last, 1'b0);
      chkw("rst_idx", 256'(vec_idx), 256'd0);
      chk1("rst_ram_r", ram_r, 1'b0);
      chk1("rst_ram_w", ram_w, 1'b0);
      chk1("rst_ack", host_wr_ack, 1'b0);
      rst = 1'b0;

      // load word k = k
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         host_wr_req = 1'b1; host_wr_addr = 9'(k); host_wr_data = 256'(k);
         #1;
         chk1("load_ack", host_wr_ack, 1'b1);
         chk1("load_ram_w", ram_w, 1'b1);
         chk1("load_ram_r", ram_r, 1'b1);
         chkw("load_addr", 256'(ram_addr), 256'(k));
         chkw("load_din", ram_din, 256'(k));
      end

      // full scan with a 5-cycle stall at idx 10, stray start at idx 100
      @(negedge clk);
      host_wr_req = 1'b0; start = 1'b1; vec_ready = 1'b1;
      #1;
      chk1("start_ram_r", ram_r, 1'b0);
      chk1("start_busy", busy, 1'b0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk1("e0_busy", busy, 1'b1);
      chk1("e0_valid", vec_valid, 1'b0);
      chk1("e0_ram_r", ram_r, 1'b1);
      chkw("e0_addr", 256'(ram_addr), 256'd0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 10) begin
            vec_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               if (s > 0) @(negedge clk);
               #1;
               chk1("stall_valid", vec_valid, 1'b1);
               chkw("stall_idx", 256'(vec_idx), 256'd10);
               chkw("stall_data", vec_data, 256'd10);
               chk1("stall_ram_r", ram_r, 1'b0);
            end
            @(negedge clk);
            vec_ready = 1'b1;
         end
         start = (i == 100);
         #1;
         chk1("scan_valid", vec_valid, 1'b1);
         chkw("scan_idx", 256'(vec_idx), 256'(i));
         chkw("scan_data", vec_data, 256'(i));
         chk1("scan_last", vec_last, i == 299);
         chk1("scan_done", done, 1'b0);
         chk1("scan_ram_r", ram_r, i != 299);
         chk1("scan_ram_w", ram_w, 1'b0);
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      chk1("end_done", done, 1'b1);
      chk1("end_valid", vec_valid, 1'b0);
      chk1("end_busy", busy, 1'b0);
      @(negedge clk); #1;
      chk1("end_done_pulse", done, 1'b0);

      // start and write together: start wins, write waits for done
      @(negedge clk);
      start = 1'b1; host_wr_req = 1'b1; host_wr_addr = 9'd400; host_wr_data = 256'hABC;
      #1;
      chk1("arb_ack0", host_wr_ack, 1'b0);
      chk1("arb_ram_w0", ram_w, 1'b0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk1("arb_ack1", host_wr_ack, 1'b0);
      chk1("arb_busy", busy, 1'b1);
      cnt = 0; early_ack = 1'b0;
      while (!done && cnt < 400) begin
         @(negedge clk); #1;
         if (host_wr_ack && !done) early_ack = 1'b1;
         cnt++;
      end
      chk1("arb_done", done, 1'b1);
      chkw("arb_cycles", 256'(cnt), 256'd301);
      chk1("arb_early_ack", early_ack, 1'b0);
      chk1("arb_ack", host_wr_ack, 1'b1);
      chk1("arb_ram_w", ram_w, 1'b1);
      chkw("arb_addr", 256'(ram_addr), 256'd400);
      chkw("arb_din", ram_din, 256'hABC);
      @(negedge clk);
      host_wr_req = 1'b0;
      #1;
      chk1("arb_ack_off", host_wr_ack, 1'b0);
      chkw("arb_mem", mem_a[400], 256'hABC);

      // reset in the middle of a scan
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i <= 150; i++) @(negedge clk);
      #1;
      chkw("mid_idx", 256'(vec_idx), 256'd150);
      rst = 1'b1;
      #1;
      chk1("mid_valid", vec_valid, 1'b0);
      chk1("mid_busy", busy, 1'b0);
      chk1("mid_ram_r", ram_r, 1'b0);
      chkw("mid_idx0", 256'(vec_idx), 256'd0);
      chk1("mid_last", vec_last, 1'b0);
      chk1("mid_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk1("post_rst_done", done, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); #1;
      chk1("rescan_valid", vec_valid, 1'b1);
      chkw("rescan_idx0", 256'(vec_idx), 256'd0);
      chkw("rescan_data0", vec_data, 256'd0);
      @(negedge clk); #1;
      chkw("rescan_idx1", 256'(vec_idx), 256'd1);
      chkw("rescan_data1", vec_data, 256'd1);
      cnt = 0;
      while (!done && cnt < 400) begin
         @(negedge clk); #1;
         cnt++;
      end
      chk1("rescan_done", done, 1'b1);

      // single-vector scan on the 5..5 instance
      @(negedge clk);
      req5 = 1'b1; addr5 = 9'd5; wdata5 = 256'h55;
      #1;
      chk1("s5_ack", ack5, 1'b1);
      @(negedge clk);
      req5 = 1'b0; start5 = 1'b1; ready5 = 1'b0;
      @(negedge clk);
      start5 = 1'b0;
      #1;
      chk1("s5_busy", busy5, 1'b1);
      chk1("s5_ram_r", ram_r5, 1'b1);
      chkw("s5_addr", 256'(ram_addr5), 256'd5);
      @(negedge clk); #1;
      chk1("s5_valid", valid5, 1'b1);
      chkw("s5_idx", 256'(idx5), 256'd5);
      chk1("s5_last", last5, 1'b1);
      chkw("s5_data", data5, 256'h55);
      chk1("s5_ram_r_drain", ram_r5, 1'b0);
      @(negedge clk);
      ready5 = 1'b1;
      #1;
      chk1("s5_hold_valid", valid5, 1'b1);
      chk1("s5_no_done", done5, 1'b0);
      @(negedge clk); #1;
      chk1("s5_done", done5, 1'b1);
      chk1("s5_valid_off", valid5, 1'b0);
      chk1("s5_busy_off", busy5, 1'b0);
      @(negedge clk); #1;
      chk1("s5_done_pulse", done5, 1'b0);

`ifdef KNN_SCAN_ABORT_EN
      // abort at idx 40 with ready held high
      @(negedge clk); start = 1'b1; vec_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 40; i++) @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      #1;
      chkw("ab_idx", 256'(vec_idx), 256'd40);
      chk1("ab_ram_r", ram_r, 1'b0);
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk1("ab_aborted", aborted, 1'b1);
      chk1("ab_valid", vec_valid, 1'b0);
      chk1("ab_last", vec_last, 1'b0);
      chk1("ab_busy", busy, 1'b0);
      chk1("ab_done", done, 1'b0);
      @(negedge clk); #1;
      chk1("ab_pulse", aborted, 1'b0);
      chk1("ab_done2", done, 1'b0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); #1;
      chkw("ab_rescan_idx", 256'(vec_idx), 256'd0);
      chkw("ab_rescan_data", vec_data, 256'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
